mem_io_bridge: RTL

- Sits directly downstream of the LC-3 CPU core's memory port.
- Consumes mem_addr, mem_wdata, mem_mem_ena and mem_wr_ena from the core and returns mem_rdata.
- Decodes each access to either a synchronous on-chip RAM with fixed read latency, or to memory-mapped I/O: switches on read, hex display on write.
- Sequences RAM enables and write pulses, and reports completion via mem_busy so the core's control FSM can size its wait states.

---
 rtl/mem_io_bridge_if.sv | 24 ++
 rtl/mem_io_bridge.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_io_bridge_if.sv
// Core-side memory port of the LC-3 memory/I-O bridge.
// Latency: n/a (signal bundle only).
// Backpressure: the core holds mem_mem_ena and watches mem_busy; there is no ready signal.
//
// master: the CPU core (drives address, write data, request, write flag)
// slave : mem_io_bridge (returns registered read data and busy)
interface mem_io_bridge_if;
  logic [15:0] mem_addr;     // core MAR
  logic [15:0] mem_wdata;    // core MDR
  logic        mem_mem_ena;  // access request, held for the whole access
  logic        mem_wr_ena;   // 1 = write, 0 = read
  logic [15:0] mem_rdata;    // registered read data
  logic        mem_busy;     // registered, high while an accepted access is in progress

  modport master (
    output mem_addr, mem_wdata, mem_mem_ena, mem_wr_ena,
    input  mem_rdata, mem_busy
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_mem_ena, mem_wr_ena,
    output mem_rdata, mem_busy
  );
endinterface

// File: rtl/mem_io_bridge.sv
// LC-3 memory bridge: decodes core accesses to a sync RAM or the switch/hex I/O register.
// Latency: RAM read data on mem_rdata RD_LATENCY+1 edges after accept; RAM write, I/O and unmapped complete at the accept edge.
// Backpressure: none; mem_busy is held while a RAM access is outstanding and the core must keep its request up.
//
// Ports:
//   clk, reset     system clock (rising edge), asynchronous active-low reset
//   core           mem_io_bridge_if.slave: mem_addr/mem_wdata/mem_mem_ena/mem_wr_ena in,
//                  mem_rdata/mem_busy out (both registered)
//   sw_i           board switches (asynchronous, double-synchronised here)
//   hex_o          hex display value, updated by writes to IO_ADDR
//   ram_*          synchronous RAM port: registered addr/wdata, one-cycle en/we pulses, rdata in
//   err_o          only with MEM_IO_BRIDGE_ERR_EN defined: sticky flag set by any unmapped access
module mem_io_bridge #(
  parameter int          RAM_ADDR_WIDTH = 10,       // 1..16
  parameter int          RD_LATENCY     = 2,        // 1..7
  parameter logic [15:0] IO_ADDR        = 16'hFFFF
) (
  input  logic                      clk,
  input  logic                      reset,
  mem_io_bridge_if.slave            core,
  input  logic [15:0]               sw_i,
  output logic [15:0]               hex_o,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
  output logic [15:0]               ram_wdata,
  output logic                      ram_en,
  output logic                      ram_we,
  input  logic [15:0]               ram_rdata
`ifdef MEM_IO_BRIDGE_ERR_EN
  ,
  output logic                      err_o
`endif
);

  localparam logic [31:0] RAM_WORDS = 32'd1 << RAM_ADDR_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    DEC_RAM      = 2'd0,
    DEC_IO       = 2'd1,
    DEC_UNMAPPED = 2'd2
  } dec_t;

  state_t state_q, state_d;
  dec_t   dec;

  logic        accept;
  logic        same_access;

  // Captured request, used in DONE to tell a held request from a new one.
  logic [15:0] cap_addr_q, cap_addr_d;
  logic        cap_wr_q, cap_wr_d;

  logic [2:0]  cnt_q, cnt_d;

  logic [15:0]               rdata_q, rdata_d;
  logic                      busy_q, busy_d;
  logic [15:0]               hex_q, hex_d;
  logic                      ram_en_q, ram_en_d;
  logic                      ram_we_q, ram_we_d;
  logic [RAM_ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [15:0]               ram_wdata_q, ram_wdata_d;

  logic [15:0] sw_meta_q, sw_sync_q;

  // Address decode on the live request; it is only acted on at an accept edge.
  // The I/O register wins over the RAM range if the two ever overlap.
  always_comb begin
    dec = DEC_UNMAPPED;
    if (core.mem_addr == IO_ADDR) begin
      dec = DEC_IO;
    end else if (32'(core.mem_addr) < RAM_WORDS) begin
      dec = DEC_RAM;
    end
  end

  assign same_access = (core.mem_addr == cap_addr_q) && (core.mem_wr_ena == cap_wr_q);

  // A held request in DONE with unchanged address and direction is the same
  // access still being held by the core, not a new one.
  assign accept = core.mem_mem_ena &&
                  ((state_q == ST_IDLE) || ((state_q == ST_DONE) && !same_access));

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          state_d = ((dec == DEC_RAM) && !core.mem_wr_ena) ? ST_RD_WAIT : ST_DONE;
        end else if (!core.mem_mem_ena) begin
          state_d = ST_IDLE;
        end
      end
      ST_RD_WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output / datapath next values.
  always_comb begin
    cap_addr_d  = cap_addr_q;
    cap_wr_d    = cap_wr_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    busy_d      = busy_q;
    hex_d       = hex_q;
    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;

    case (state_q)
      ST_RD_WAIT: begin
        // The counter is loaded with RD_LATENCY at accept; the first edge in
        // RD_WAIT is the one where the RAM samples ram_en, so data is taken
        // when the count has run out, RD_LATENCY+1 edges after accept.
        if (cnt_q == 3'd0) begin
          rdata_d = ram_rdata;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: begin
        // Ends the single busy cycle of a RAM write.
        busy_d = 1'b0;
        if (accept) begin
          cap_addr_d = core.mem_addr;
          cap_wr_d   = core.mem_wr_ena;
          case (dec)
            DEC_RAM: begin
              ram_en_d   = 1'b1;
              ram_we_d   = core.mem_wr_ena;
              ram_addr_d = core.mem_addr[RAM_ADDR_WIDTH-1:0];
              busy_d     = 1'b1;
              if (core.mem_wr_ena) begin
                ram_wdata_d = core.mem_wdata;
              end else begin
                cnt_d = 3'(RD_LATENCY);
              end
            end
            DEC_IO: begin
              if (core.mem_wr_ena) begin
                hex_d = core.mem_wdata;
              end else begin
                rdata_d = sw_sync_q;
              end
            end
            default: begin
              // Unmapped: reads return zero, writes are dropped.
              if (!core.mem_wr_ena) begin
                rdata_d = 16'h0000;
              end
            end
          endcase
        end
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_addr_q  <= 16'h0000;
      cap_wr_q    <= 1'b0;
      cnt_q       <= 3'd0;
      rdata_q     <= 16'h0000;
      busy_q      <= 1'b0;
      hex_q       <= 16'h0000;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= 16'h0000;
      sw_meta_q   <= 16'h0000;
      sw_sync_q   <= 16'h0000;
    end else begin
      cap_addr_q  <= cap_addr_d;
      cap_wr_q    <= cap_wr_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      busy_q      <= busy_d;
      hex_q       <= hex_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      sw_meta_q   <= sw_i;
      sw_sync_q   <= sw_meta_q;
    end
  end

`ifdef MEM_IO_BRIDGE_ERR_EN
  logic err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (accept && (dec == DEC_UNMAPPED)) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`endif

  assign core.mem_rdata = rdata_q;
  assign core.mem_busy  = busy_q;
  assign hex_o          = hex_q;
  assign ram_en         = ram_en_q;
  assign ram_we         = ram_we_q;
  assign ram_addr       = ram_addr_q;
  assign ram_wdata      = ram_wdata_q;

endmodule
